// File: rtl/store_queue_pkg.sv
// Shared opcode encodings and entry-field widths for the store queue.
// Latency: n/a (constants only).
// Backpressure: n/a.
package store_queue_pkg;

  localparam int ADDR_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ST_B  = 3'd0;
  localparam logic [OP_W-1:0] ST_H  = 3'd1;
  localparam logic [OP_W-1:0] ST_W  = 3'd2;
  localparam logic [OP_W-1:0] ST_D  = 3'd3;
  localparam logic [OP_W-1:0] ST_WL = 3'd4;
  localparam logic [OP_W-1:0] ST_WR = 3'd5;

  // Number of address bits that select a byte lane within one memory word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/store_align.sv
// Maps a store (op, low address bits, register data) to lane enables and lane-aligned data.
// Latency: purely combinational.
// Backpressure: none; adex flags misaligned or illegal requests (STORE_QUEUE_SWLR_EN enables ST_WL/ST_WR).
module store_align
  import store_queue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]     op,
  input  logic [2:0]          addr_lo,
  input  logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] wen,
  output logic [DATA_W-1:0]   wdata,
  output logic                adex
);

  localparam int NB = DATA_W / 8;
  localparam int LB = lane_bits(DATA_W);

  localparam logic [NB-1:0] M1   = NB'(1);
  localparam logic [NB-1:0] M2   = NB'(3);
  localparam logic [NB-1:0] M4   = NB'(15);
  localparam logic [NB-1:0] MALL = '1;

  logic [LB-1:0] k;
  logic [1:0]    kw;

  assign k  = addr_lo[LB-1:0];
  assign kw = addr_lo[1:0];

`ifdef STORE_QUEUE_SWLR_EN
  // Lane of byte 0 of the addressed 32-bit word, and the partial-word masks within it.
  logic [LB-1:0] wbase;
  logic [3:0]    mask_wl;
  logic [3:0]    mask_wr;
  assign wbase   = k & ~LB'(3);
  assign mask_wl = 4'((5'd2 << kw) - 5'd1);
  assign mask_wr = 4'(4'hF << kw);
`endif

  // Decode the opcode into lane enables, replicated data and the alignment fault.
  always_comb begin
    wen   = '0;
    wdata = '0;
    adex  = 1'b0;
    case (op)
      ST_B: begin
        wen   = M1 << k;
        wdata = {NB{data[7:0]}};
      end
      ST_H: begin
        adex  = addr_lo[0];
        wen   = M2 << k;
        wdata = {(NB/2){data[15:0]}};
      end
      ST_W: begin
        adex  = (kw != 2'd0);
        wen   = M4 << k;
        wdata = {(NB/4){data[31:0]}};
      end
      ST_D: begin
        adex  = (DATA_W == 32) || (addr_lo != 3'd0);
        wen   = MALL;
        wdata = data;
      end
`ifdef STORE_QUEUE_SWLR_EN
      ST_WL: begin
        wen   = NB'(mask_wl) << wbase;
        wdata = {(NB/4){data[31:0] >> (8 * (3 - kw))}};
      end
      ST_WR: begin
        wen   = NB'(mask_wr) << wbase;
        wdata = {(NB/4){data[31:0] << (8 * kw)}};
      end
`endif
      default: adex = 1'b1;
    endcase
    // A rejected store never reaches the queue; keep its enables quiet.
    if (adex) wen = '0;
  end

endmodule

// File: rtl/store_queue.sv
// In-order store queue: aligns stores, buffers DEPTH entries, presents head to memory.
// Latency: enqueue into empty queue shows mem_req the next cycle; outputs come from entry registers.
// Backpressure: in_ready = !full (no bypass); mem_ack retires head; flush drops all. STORE_QUEUE_SWLR_EN adds ST_WL/ST_WR.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_W-1:0]              in_op,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         st_adex,
  input  logic                         flush,
  output logic                         mem_req,
  input  logic                         mem_ack,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W/8-1:0]          mem_wen,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = lane_bits(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [NB-1:0]     q_wen   [DEPTH];
  logic [DATA_W-1:0] q_wdata [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [NB-1:0]     al_wen;
  logic [DATA_W-1:0] al_wdata;
  logic              enq;
  logic              deq;

  store_align #(.DATA_W(DATA_W)) u_align (
    .op      (in_op),
    .addr_lo (in_addr[2:0]),
    .data    (in_data),
    .wen     (al_wen),
    .wdata   (al_wdata),
    .adex    (st_adex)
  );

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign mem_req   = (count != '0);
  assign enq       = in_valid && in_ready && !st_adex && !flush;
  assign deq       = mem_req && mem_ack;
  assign mem_addr  = q_addr[rptr];
  assign mem_wen   = q_wen[rptr];
  assign mem_wdata = q_wdata[rptr];

  // Entry storage: written at the tail on enqueue, cleared by reset so the idle head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i]  <= '0;
        q_wen[i]   <= '0;
        q_wdata[i] <= '0;
      end
    end else if (enq) begin
      q_addr[wptr]  <= {in_addr[ADDR_W-1:LB], LB'(0)};
      q_wen[wptr]   <= al_wen;
      q_wdata[wptr] <= al_wdata;
    end
  end

  // Pointers and occupancy; flush empties the queue, and a same-cycle ack simply retires with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + PTR_W'(1);
      if (deq) rptr <= rptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
  import store_queue_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        adex;
    logic [31:0] eaddr;
    logic [3:0]  ewen;
    logic [31:0] ewdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0, flush = 1'b0, ack = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0, data = '0;
  logic        ready, adex, req;
  logic [31:0] maddr, wdata;
  logic [3:0]  wen;
  logic [2:0]  cnt;

  logic        rst64 = 1'b0;
  logic        valid64 = 1'b0, flush64 = 1'b0, ack64 = 1'b0;
  logic [2:0]  op64 = '0;
  logic [31:0] addr64 = '0;
  logic [63:0] data64 = '0;
  logic        ready64, adex64, req64;
  logic [31:0] maddr64;
  logic [63:0] wdata64;
  logic [7:0]  wen64;
  logic [2:0]  cnt64;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  store_queue #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(valid), .in_ready(ready), .in_op(op),
    .in_addr(addr), .in_data(data), .st_adex(adex), .flush(flush),
    .mem_req(req), .mem_ack(ack), .mem_addr(maddr), .mem_wen(wen),
    .mem_wdata(wdata), .count(cnt)
  );

  store_queue #(.DATA_W(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst64), .in_valid(valid64), .in_ready(ready64), .in_op(op64),
    .in_addr(addr64), .in_data(data64), .st_adex(adex64), .flush(flush64),
    .mem_req(req64), .mem_ack(ack64), .mem_addr(maddr64), .mem_wen(wen64),
    .mem_wdata(wdata64), .count(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                              input logic x, input logic [31:0] ea, input logic [3:0] ew,
                              input logic [31:0] ed);
    vec_t v;
    v.op = o; v.addr = a; v.data = d; v.adex = x;
    v.eaddr = ea; v.ewen = ew; v.ewdata = ed;
    return v;
  endfunction

  // Retire every scoreboard entry in order, comparing the head before each ack.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("drain_req", req, 1);
      chk("drain_addr", maddr, e.addr);
      chk("drain_wen", wen, e.wen);
      chk("drain_wdata", wdata, e.wdata);
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
    end
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    valid = 1'b1; op = v.op; addr = v.addr; data = v.data;
    #1;
    chk("vec_adex", adex, v.adex);
    if (!v.adex) sb.push_back('{v.eaddr, v.ewen, v.ewdata});
    @(posedge clk); #1;
    valid = 1'b0;
    chk("vec_req_latency", req, !v.adex);
    drain();
    chk("vec_count_zero", cnt, 0);
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; op = ST_W; addr = a; data = d;
  endtask

  initial begin
    vecs[0]  = mk(ST_B, 32'h1003, 32'h0000_00AB, 0, 32'h1000, 4'b1000, 32'hABAB_ABAB);
    vecs[1]  = mk(ST_H, 32'h2001, 32'h0000_1234, 1, 0, 0, 0);
    vecs[2]  = mk(ST_H, 32'h2002, 32'h1234_BEEF, 0, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
    vecs[3]  = mk(ST_W, 32'h3000, 32'hDEAD_BEEF, 0, 32'h3000, 4'b1111, 32'hDEAD_BEEF);
    vecs[4]  = mk(ST_W, 32'h3002, 32'hDEAD_BEEF, 1, 0, 0, 0);
    vecs[5]  = mk(ST_D, 32'h4000, 32'h0102_0304, 1, 0, 0, 0);
    vecs[6]  = mk(3'd6, 32'h4000, 32'h0102_0304, 1, 0, 0, 0);
    vecs[7]  = mk(3'd7, 32'h4000, 32'h0102_0304, 1, 0, 0, 0);
    vecs[8]  = mk(ST_B, 32'h5000, 32'h1234_5678, 0, 32'h5000, 4'b0001, 32'h7878_7878);
`ifdef STORE_QUEUE_SWLR_EN
    vecs[9]  = mk(ST_WL, 32'h3001, 32'h1122_3344, 0, 32'h3000, 4'b0011, 32'h0000_1122);
    vecs[10] = mk(ST_WR, 32'h3001, 32'h1122_3344, 0, 32'h3000, 4'b1110, 32'h2233_4400);
`else
    vecs[9]  = mk(ST_WL, 32'h3001, 32'h1122_3344, 1, 0, 0, 0);
    vecs[10] = mk(ST_WR, 32'h3001, 32'h1122_3344, 1, 0, 0, 0);
`endif

    // Reset state.
    #1 rst = 1'b1; rst64 = 1'b1;
    #1;
    chk("rst_req", req, 0);
    chk("rst_count", cnt, 0);
    chk("rst_wen", wen, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_req64", req64, 0);
    @(negedge clk);
    rst = 1'b0; rst64 = 1'b0;
    #1 chk("rst_ready", ready, 1);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Ack with an empty queue is ignored.
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    chk("idle_ack_count", cnt, 0);
    chk("idle_ack_req", req, 0);

    // Fill to DEPTH; the fifth store must be held off.
    for (int i = 0; i < 5; i++) begin
      push_w(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      #1;
      if (i < 4) sb.push_back('{32'h100 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i)});
      else chk("full_ready_low", ready, 0);
      @(posedge clk); #1;
      if (i == 3) chk("full_count", cnt, 4);
    end
    valid = 1'b0;
    chk("full_fifth_dropped", cnt, 4);
    @(negedge clk);
    chk("full_head_stable", maddr, 32'h100);
    drain();
    chk("full_drained", cnt, 0);

    // Simultaneous enqueue and dequeue keeps count.
    push_w(32'h200, 32'h11);
    @(posedge clk); #1;
    push_w(32'h204, 32'h22);
    ack = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; ack = 1'b0;
    chk("enq_deq_count", cnt, 1);
    chk("enq_deq_head", maddr, 32'h204);
    sb.push_back('{32'h204, 4'hF, 32'h22});
    drain();

    // Full queue, flush with same-cycle ack: the head write completes, everything else is dropped.
    for (int i = 0; i < 4; i++) begin
      push_w(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
      @(posedge clk); #1;
    end
    @(negedge clk);
    valid = 1'b1; addr = 32'h400; data = 32'h55;
    flush = 1'b1; ack = 1'b1;
    #1;
    chk("flush_head_req", req, 1);
    chk("flush_head_addr", maddr, 32'h300);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0; ack = 1'b0;
    chk("flush_count", cnt, 0);
    chk("flush_req", req, 0);
    chk("flush_ready", ready, 1);
    @(posedge clk); #1;
    chk("flush_stays_empty", cnt, 0);

    // 64-bit data path.
    @(negedge clk);
    valid64 = 1'b1; op64 = ST_W; addr64 = 32'h4004; data64 = 64'h0000_0000_CAFE_F00D;
    #1 chk("d64_w_adex", adex64, 0);
    @(posedge clk); #1 valid64 = 1'b0;
    chk("d64_w_req", req64, 1);
    chk("d64_w_addr", maddr64, 32'h4000);
    chk("d64_w_wen", wen64, 8'hF0);
    chk("d64_w_wdata", wdata64, 64'hCAFE_F00D_CAFE_F00D);
    ack64 = 1'b1; @(posedge clk); #1 ack64 = 1'b0;

    @(negedge clk);
    valid64 = 1'b1; op64 = ST_D; addr64 = 32'h4008; data64 = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1 valid64 = 1'b0;
    chk("d64_d_wen", wen64, 8'hFF);
    chk("d64_d_wdata", wdata64, 64'h0123_4567_89AB_CDEF);
    ack64 = 1'b1; @(posedge clk); #1 ack64 = 1'b0;
    chk("d64_d_count", cnt64, 0);

    @(negedge clk);
    valid64 = 1'b1; op64 = ST_D; addr64 = 32'h400C;
    #1 chk("d64_d_misaligned", adex64, 1);

`ifdef STORE_QUEUE_SWLR_EN
    op64 = ST_WL; addr64 = 32'h4005; data64 = 64'h0000_0000_1122_3344;
    #1 chk("d64_wl_adex", adex64, 0);
    @(posedge clk); #1 valid64 = 1'b0;
    chk("d64_wl_wen", wen64, 8'h30);
    chk("d64_wl_wdata", wdata64, 64'h0000_1122_0000_1122);
    ack64 = 1'b1; @(posedge clk); #1 ack64 = 1'b0;
`else
    op64 = ST_WL; addr64 = 32'h4005;
    #1 chk("d64_wl_adex", adex64, 1);
    @(posedge clk); #1 valid64 = 1'b0;
`endif

    // Reset during a pending transfer abandons the head.
    @(negedge clk);
    valid64 = 1'b1; op64 = ST_B; addr64 = 32'h4005; data64 = 64'h5A;
    @(posedge clk); #1 valid64 = 1'b0;
    chk("d64_b_wen", wen64, 8'h20);
    chk("d64_b_wdata", wdata64, 64'h5A5A_5A5A_5A5A_5A5A);
    rst64 = 1'b1;
    #1;
    chk("d64_rst_req", req64, 0);
    chk("d64_rst_count", cnt64, 0);
    chk("d64_rst_wen", wen64, 0);
    @(negedge clk); rst64 = 1'b0;
    @(posedge clk); #1;
    chk("d64_no_retry", req64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  store request present.
REQ-006 in_ready  output  1  queue can accept a store; equals !full, with no same-cycle bypass on full.
REQ-007 in_op  input  3  store opcode; encoding defined in the shared package (REQ-030).
REQ-008 in_addr  input  32  byte address of the store.
REQ-009 in_data  input  DATA_W  unaligned register data (rt).
REQ-010 st_adex  output  1  combinational misaligned-address or illegal-opcode flag for the current request.
REQ-011 flush  input  1  exception/pipeline flush; discards all queued stores.
REQ-012 mem_req  output  1  head entry valid.
REQ-013 mem_ack  input  1  memory accepts the head entry in this cycle.
REQ-014 mem_addr  output  32  head address, aligned to DATA_W/8 bytes.
REQ-015 mem_wen  output  DATA_W/8  head byte enables; bit i is byte lane i, little-endian.
REQ-016 mem_wdata  output  DATA_W  head lane-aligned write data.
REQ-017 count  output  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-018 Enqueue SHALL occur at the clock edge when in_valid && in_ready && !st_adex && !flush; a request with st_adex high SHALL NOT be enqueued.
REQ-019 st_adex SHALL be set for: ST_H with addr[0]!=0; ST_W with addr[1:0]!=0; ST_D with addr[2:0]!=0 or DATA_W=32; undefined opcodes.
REQ-020 Lane offset k SHALL be in_addr[log2(DATA_W/8)-1:0]; ST_B, ST_H and ST_W SHALL enable 1, 2 and 4 bytes starting at lane k, and ST_D SHALL enable all 8 lanes.
REQ-021 Write data SHALL be the low 8/16/32 bits of in_data replicated across all DATA_W/8 lane groups; ST_D SHALL use in_data unchanged.
REQ-022 Latency: a store enqueued into an empty queue SHALL present mem_req=1 in the following cycle; all mem_* outputs SHALL be driven directly from head-entry registers.
REQ-023 Dequeue SHALL occur at the clock edge when mem_req && mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 flush SHALL empty the queue at the next edge, with count=0 and mem_req=0 in the following cycle; a same-cycle enqueue SHALL be dropped, and a same-cycle mem_ack SHALL complete the write.
REQ-026 Head entry contents SHALL remain stable while mem_req=1 and mem_ack=0.

Reset
REQ-027 Asserting rst SHALL immediately clear pointers and count to 0, and drive mem_req=0, mem_wen=0, mem_addr=0 and mem_wdata=0; in_ready SHALL be 1 while rst is deasserted and the queue is not full.
REQ-028 rst asserted mid-transfer SHALL abandon the head entry, with no retry after release.

Configuration
REQ-029 Macro STORE_QUEUE_SWLR_EN: when defined, ST_WL and ST_WR are legal on any address, with k=addr[1:0] and the operation applied within the addressed 32-bit word:
  - ST_WL: enables bytes 0..k; data = rt >> 8*(3-k).
  - ST_WR: enables bytes k..3; data = rt << 8*k.
  - When undefined, ST_WL and ST_WR SHALL raise st_adex and SHALL NOT enqueue.

Structure
REQ-030 Shared package (the defines header) SHALL hold the opcode constants ST_B=0, ST_H=1, ST_W=2, ST_D=3, ST_WL=4, ST_WR=5, plus the entry-field widths.
REQ-031 One sub-module, store_align, SHALL be purely combinational and map (op, addr, data) to (wen, wdata, adex); the FIFO and pointers SHALL reside in store_queue.

Verification
REQ-032 DATA_W=32: ST_B, addr 0x1003, data 0x000000AB -> next cycle mem_req=1, mem_addr=0x1000, mem_wen=4'b1000, mem_wdata=0xABABABAB.
REQ-033 ST_H, addr 0x2001 -> st_adex=1, count stays 0, mem_req stays 0.
REQ-034 DEPTH=4: five back-to-back ST_W with mem_ack=0 -> in_ready=0 after the fourth, fifth not accepted; then ack for 4 cycles -> writes retire in order and count returns to 0.
REQ-035 Queue full, flush with mem_ack=1 in the same cycle -> exactly one write completes, count=0 next cycle, in_ready=1.
REQ-036 STORE_QUEUE_SWLR_EN defined, ST_WL, addr 0x3001, data 0x11223344 -> mem_wen=4'b0011, low 16 bits of mem_wdata=0x1122; macro undefined -> st_adex=1.
REQ-037 DATA_W=64: ST_W at addr 0x4004 -> mem_addr=0x4000, mem_wen=8'hF0; rst asserted while mem_req=1 -> mem_req=0 immediately.
